// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared FSM state type and 2-input truth-table constants for gate sweeps
package gate_test_pkg;
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
endpackage

// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer: sweeps every input vector of a gate, samples after a settle interval, checks it against TRUTH
// Ports: clk, rst (sync, active-high), start (sweep request, IDLE only), dut_in (vector to gate), dut_out (gate output),
//        busy, done (1-cycle pulse), pass, err_count, fail_valid, fail_vec (first mismatching vector)
module gate_truth_sequencer
    import gate_test_pkg::*;
#(
    parameter int                   N_IN   = 2,
    parameter int                   SETTLE = 1,
    parameter logic [2**N_IN-1:0]   TRUTH  = TT_AND
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);
    localparam int SW = $clog2(SETTLE + 1);

    state_t          state, state_nx;
    logic [N_IN-1:0] vec;
    logic [SW-1:0]   settle_cnt;
    logic            last_settle, last_vec, mismatch;

    assign dut_in      = vec;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign last_settle = settle_cnt == SW'(SETTLE - 1);
    assign last_vec    = &vec;
    assign mismatch    = dut_out != TRUTH[vec];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE  ? (start ? APPLY : IDLE) :
                   state == APPLY ? (last_settle ? CHECK : APPLY) :
                   state == CHECK ? (last_vec ? DONE : APPLY) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    vec        <= '0;
                    settle_cnt <= '0;
                    err_count  <= '0;
                    fail_valid <= 1'b0;
                    fail_vec   <= '0;
                    pass       <= 1'b0;
                end
                APPLY: settle_cnt <= settle_cnt + 1'b1;
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!fail_valid) begin
                            fail_vec   <= vec;
                            fail_valid <= 1'b1;
                        end
                    end
                    // pass must reflect this final CHECK so it is valid together with done
                    if (last_vec) pass <= err_count == '0 && !mismatch;
                    else begin
                        vec        <= vec + 1'b1;
                        settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb_gate_truth_sequencer: random and directed sweeps of three sequencer configurations against a table-level model
module tb_gate_truth_sequencer;
    logic clk = 0, rst = 1, start = 0;
    int   sel = 0;
    logic [3:0] gtab = 4'b1000;
    int   checks = 0, errors = 0;

    logic [1:0] in_a, in_b, fvec_a, fvec_b;
    logic [0:0] in_c, fvec_c;
    logic [2:0] err_a, err_b;
    logic [1:0] err_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c, fv_a, fv_b, fv_c;

    always #5 clk = ~clk;

    gate_truth_sequencer #(.N_IN(2), .SETTLE(1), .TRUTH(4'b1000)) u_a (
        .clk(clk), .rst(rst), .start(start && sel == 0), .dut_in(in_a), .dut_out(gtab[in_a]),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_valid(fv_a), .fail_vec(fvec_a));
    gate_truth_sequencer #(.N_IN(2), .SETTLE(3), .TRUTH(4'b1000)) u_b (
        .clk(clk), .rst(rst), .start(start && sel == 1), .dut_in(in_b), .dut_out(gtab[in_b]),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .fail_valid(fv_b), .fail_vec(fvec_b));
    gate_truth_sequencer #(.N_IN(1), .SETTLE(1), .TRUTH(2'b01)) u_c (
        .clk(clk), .rst(rst), .start(start && sel == 2), .dut_in(in_c), .dut_out(gtab[in_c]),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .fail_valid(fv_c), .fail_vec(fvec_c));

    logic [1:0] m_in, m_fvec;
    logic [2:0] m_err;
    logic m_busy, m_done, m_pass, m_fv;
    always_comb begin
        m_in   = sel == 2 ? {1'b0, in_c}   : sel == 1 ? in_b   : in_a;
        m_fvec = sel == 2 ? {1'b0, fvec_c} : sel == 1 ? fvec_b : fvec_a;
        m_err  = sel == 2 ? {1'b0, err_c}  : sel == 1 ? err_b  : err_a;
        m_busy = sel == 2 ? busy_c : sel == 1 ? busy_b : busy_a;
        m_done = sel == 2 ? done_c : sel == 1 ? done_b : done_a;
        m_pass = sel == 2 ? pass_c : sel == 1 ? pass_b : pass_a;
        m_fv   = sel == 2 ? fv_c   : sel == 1 ? fv_b   : fv_a;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in"}, m_in, 0);
        chk({tag, "_busy"}, m_busy, 0);
        chk({tag, "_done"}, m_done, 0);
        chk({tag, "_pass"}, m_pass, 0);
        chk({tag, "_err"}, m_err, 0);
        chk({tag, "_fv"}, m_fv, 0);
        chk({tag, "_fvec"}, m_fvec, 0);
    endtask

    task automatic sweep(input int s, input logic [3:0] tab, input bit extra);
        int n = s == 2 ? 1 : 2;
        int settle = s == 1 ? 3 : 1;
        logic [3:0] truth = s == 2 ? 4'b0001 : 4'b1000;
        int nv = 1 << n;
        int exp_err = 0, exp_fvec = 0, exp_lat, cyc;
        bit exp_fv = 0;
        for (int v = 0; v < nv; v++)
            if (tab[v] != truth[v]) begin
                exp_err++;
                if (!exp_fv) begin exp_fv = 1; exp_fvec = v; end
            end
        exp_lat = nv * (settle + 1) + 1;
        sel = s;
        gtab = tab;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        cyc = 1;
        chk("busy_after_start", m_busy, 1);
        while (!m_done && cyc < 200) begin
            if (cyc <= nv * (settle + 1)) chk("vec_seq", m_in, (cyc - 1) / (settle + 1));
            start = extra ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            start = 0;
            cyc++;
        end
        if (cyc >= 200) chk("done_timeout", 0, 1);
        chk("latency", cyc, exp_lat);
        chk("done", m_done, 1);
        chk("pass", m_pass, exp_err == 0);
        chk("err_count", m_err, exp_err);
        chk("fail_valid", m_fv, exp_fv);
        chk("fail_vec", m_fvec, exp_fvec);
        start = extra;
        @(posedge clk); #1;
        start = 0;
        chk("done_pulse_end", m_done, 0);
        chk("idle_after_done", m_busy, 0);
        chk("pass_hold", m_pass, exp_err == 0);
        chk("err_hold", m_err, exp_err);
        chk("in_hold", m_in, nv - 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0 chk_reset_vals("reset");
        end
        sweep(0, 4'b1000, 0);
        sweep(0, 4'b0000, 0);
        sweep(0, 4'b1111, 0);
        sweep(0, 4'b1000, 0);
        sweep(0, 4'b0110, 0);
        sweep(1, 4'b1000, 1);
        sweep(2, 4'b0001, 0);
        sweep(2, 4'b0010, 1);
        sel = 0;
        gtab = 4'b1111;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (5) @(posedge clk);
        #1 chk("reach_check_v2", m_in, 2);
        chk("err_before_rst", m_err, 2);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk_reset_vals("mid_rst");
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (m_done || m_busy) chk("no_done_after_rst", {m_busy, m_done}, 0);
        end
        rst = 1;
        start = 1;
        @(posedge clk); #1;
        rst = 0;
        start = 0;
        chk("rst_beats_start", m_busy, 0);
        sweep(0, 4'b1000, 0);
        for (int i = 0; i < 24; i++) begin
            sweep($urandom_range(0, 2), 4'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
